// File: rtl/dino_level_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// dino_level_ctrl_pkg
// Shared constants for the Dino Run progress logic: game-phase encoding,
// difficulty-level width and the default score thresholds. The display and
// scoreboard logic import this package as well.
// -----------------------------------------------------------------------------
package dino_level_ctrl_pkg;

    localparam int LEVEL_W = 2;
    typedef logic [LEVEL_W-1:0] level_t;

    localparam level_t LEVEL_MAX = level_t'(3);

    localparam int STATE_W = 2;
    localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] ST_RUN  = 2'd1;
    localparam logic [STATE_W-1:0] ST_OVER = 2'd2;

    localparam int unsigned DEF_SCORE_W   = 14;
    localparam int unsigned DEF_SCORE_MAX = 9999;
    localparam int unsigned DEF_L1_THRESH = 100;
    localparam int unsigned DEF_L2_THRESH = 300;
    localparam int unsigned DEF_L3_THRESH = 600;

endpackage

// File: rtl/dino_level_ctrl_if.sv
// -----------------------------------------------------------------------------
// dino_level_ctrl_if
// Bundles the game-control inputs and progress outputs of dino_level_ctrl.
//   master : drives score_clk/start/collision, observes the progress outputs
//   slave  : the controller itself
// Signals:
//   score_clk  divided tick level (clk-derived)
//   start      one-cycle start/restart pulse
//   collision  high while the dino overlaps an obstacle
//   level      difficulty level 0..3
//   score      current score
//   high_score best score since reset
//   level_up   one-cycle pulse on each level increase
//   running    high in RUN
//   game_over  high in OVER
// -----------------------------------------------------------------------------
interface dino_level_ctrl_if
    import dino_level_ctrl_pkg::*;
#(
    parameter int unsigned SCORE_W = DEF_SCORE_W
);
    logic               score_clk;
    logic               start;
    logic               collision;
    level_t             level;
    logic [SCORE_W-1:0] score;
    logic [SCORE_W-1:0] high_score;
    logic               level_up;
    logic               running;
    logic               game_over;

    modport master (
        output score_clk, start, collision,
        input  level, score, high_score, level_up, running, game_over
    );

    modport slave (
        input  score_clk, start, collision,
        output level, score, high_score, level_up, running, game_over
    );
endinterface

// File: rtl/dino_tick_edge.sv
// -----------------------------------------------------------------------------
// dino_tick_edge
// Rising-edge detector for a clk-derived tick level (score_clk, obstacle_clk,
// two_hz). A level held high produces exactly one tick_rise cycle.
// Ports:
//   clk       master clock
//   clr_n     asynchronous reset, active-low
//   tick_in   tick level, already synchronous to clk
//   tick_rise one-cycle pulse on the 0->1 transition of tick_in
// -----------------------------------------------------------------------------
module dino_tick_edge (
    input  logic clk,
    input  logic clr_n,
    input  logic tick_in,
    output logic tick_rise
);
    logic tick_prev;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            tick_prev <= 1'b0;
        end else begin
            tick_prev <= tick_in;
        end
    end

    assign tick_rise = tick_in & ~tick_prev;

endmodule

// File: rtl/dino_level_ctrl.sv
// -----------------------------------------------------------------------------
// dino_level_ctrl
// Game-progress controller for Dino Run. Counts score on score_clk rising
// edges, derives the difficulty level that selects the cactus clock rate,
// sequences IDLE/RUN/OVER and keeps the high score.
// Thresholds must satisfy L1_THRESH < L2_THRESH < L3_THRESH <= SCORE_MAX.
// Ports:
//   clk    master clock, 50 MHz
//   clr_n  asynchronous reset, active-low
//   bus    slave side of dino_level_ctrl_if (inputs + progress outputs)
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | after reset; score/level held at 0, waiting for start
// RUN     | counting ticks; collision ends the game
// OVER    | score/level/high_score frozen; start restarts from 0
// -----------------------------------------------------------------------------
module dino_level_ctrl
    import dino_level_ctrl_pkg::*;
#(
    parameter int unsigned SCORE_W   = DEF_SCORE_W,
    parameter int unsigned SCORE_MAX = DEF_SCORE_MAX,
    parameter int unsigned L1_THRESH = DEF_L1_THRESH,
    parameter int unsigned L2_THRESH = DEF_L2_THRESH,
    parameter int unsigned L3_THRESH = DEF_L3_THRESH
) (
    input  logic               clk,
    input  logic               clr_n,
    dino_level_ctrl_if.slave   bus
);
    localparam logic [SCORE_W-1:0] MAX_V = SCORE_W'(SCORE_MAX);
    localparam logic [SCORE_W-1:0] L1_V  = SCORE_W'(L1_THRESH);
    localparam logic [SCORE_W-1:0] L2_V  = SCORE_W'(L2_THRESH);
    localparam logic [SCORE_W-1:0] L3_V  = SCORE_W'(L3_THRESH);

    logic [STATE_W-1:0] state;
    logic [SCORE_W-1:0] score_q;
    logic [SCORE_W-1:0] high_q;
    level_t             level_q;
    level_t             level_nxt;
    logic               level_up_q;
    logic               tick_rise;

    // Priority encoding keeps the result sane even if a score ever jumped
    // past more than one threshold.
    function automatic level_t level_of(input logic [SCORE_W-1:0] s);
        if (s >= L3_V) begin
            return LEVEL_MAX;
        end else if (s >= L2_V) begin
            return level_t'(2);
        end else if (s >= L1_V) begin
            return level_t'(1);
        end
        return level_t'(0);
    endfunction

    dino_tick_edge u_tick (
        .clk       (clk),
        .clr_n     (clr_n),
        .tick_in   (bus.score_clk),
        .tick_rise (tick_rise)
    );

    // Level is derived from the registered score, so it trails the score by
    // one clk.
    assign level_nxt = level_of(score_q);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state      <= ST_IDLE;
            score_q    <= '0;
            high_q     <= '0;
            level_q    <= '0;
            level_up_q <= 1'b0;
        end else begin
            level_up_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    score_q <= '0;
                    level_q <= '0;
                    if (bus.start) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Level keeps tracking on the collision edge too, so a
                    // threshold reached on the last tick is not lost.
                    if (level_nxt > level_q) begin
                        level_q    <= level_nxt;
                        level_up_q <= 1'b1;
                    end
                    if (bus.collision) begin
                        state <= ST_OVER;
                        if (score_q > high_q) begin
                            high_q <= score_q;
                        end
                    end else if (tick_rise && (score_q < MAX_V)) begin
                        score_q <= score_q + 1'b1;
                    end
                end
                ST_OVER: begin
                    if (bus.start) begin
                        state   <= ST_RUN;
                        score_q <= '0;
                        level_q <= '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.score      = score_q;
    assign bus.high_score = high_q;
    assign bus.level      = level_q;
    assign bus.level_up   = level_up_q;
    assign bus.running    = (state == ST_RUN);
    assign bus.game_over  = (state == ST_OVER);

endmodule

// File: tb/tb_dino_level_ctrl.sv
module tb_dino_level_ctrl;

    logic clk = 1'b0;
    logic clr_n;

    always #5 clk = ~clk;

    // bus_a: default thresholds; bus_b: L1=3, L2=5, L3=7, SCORE_MAX=8
    dino_level_ctrl_if bus_a ();
    dino_level_ctrl_if bus_b ();

    dino_level_ctrl u_a (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus_a)
    );

    dino_level_ctrl #(
        .SCORE_MAX (8),
        .L1_THRESH (3),
        .L2_THRESH (5),
        .L3_THRESH (7)
    ) u_b (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus_b)
    );

    typedef struct {
        int    dut;
        string name;
        int    score;
        int    level;
        int    high;
        bit    run;
        bit    over;
    } snap_t;

    snap_t snap_q[$];
    int    lvl_qa[$];
    int    lvl_qb[$];

    int total = 0;
    int bad   = 0;

    snap_t cur;
    int    a_score, a_level, a_high;
    bit    a_run, a_over;
    int    exp_l;

    // Monitor: compares queued snapshots and every level_up pulse the DUTs
    // present, away from the active clock edge.
    always @(negedge clk) begin
        while (snap_q.size() > 0) begin
            cur = snap_q.pop_front();
            if (cur.dut == 0) begin
                a_score = int'(bus_a.score);
                a_level = int'(bus_a.level);
                a_high  = int'(bus_a.high_score);
                a_run   = bus_a.running;
                a_over  = bus_a.game_over;
            end else begin
                a_score = int'(bus_b.score);
                a_level = int'(bus_b.level);
                a_high  = int'(bus_b.high_score);
                a_run   = bus_b.running;
                a_over  = bus_b.game_over;
            end
            total++;
            if (a_score !== cur.score || a_level !== cur.level || a_high !== cur.high ||
                a_run !== cur.run || a_over !== cur.over) begin
                bad++;
                $display("FAIL %s(dut%0d): got score=%0d level=%0d high=%0d run=%0b over=%0b, want score=%0d level=%0d high=%0d run=%0b over=%0b",
                         cur.name, cur.dut, a_score, a_level, a_high, a_run, a_over,
                         cur.score, cur.level, cur.high, cur.run, cur.over);
            end
        end
        if (bus_a.level_up === 1'b1) begin
            total++;
            if (lvl_qa.size() == 0) begin
                bad++;
                $display("FAIL level_up_a: got unexpected pulse at level=%0d, want no pulse", bus_a.level);
            end else begin
                exp_l = lvl_qa.pop_front();
                if (int'(bus_a.level) !== exp_l) begin
                    bad++;
                    $display("FAIL level_up_a: got level=%0d, want %0d", bus_a.level, exp_l);
                end
            end
        end
        if (bus_b.level_up === 1'b1) begin
            total++;
            if (lvl_qb.size() == 0) begin
                bad++;
                $display("FAIL level_up_b: got unexpected pulse at level=%0d, want no pulse", bus_b.level);
            end else begin
                exp_l = lvl_qb.pop_front();
                if (int'(bus_b.level) !== exp_l) begin
                    bad++;
                    $display("FAIL level_up_b: got level=%0d, want %0d", bus_b.level, exp_l);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int d, input logic sc, input logic st, input logic co);
        if (d == 0) begin
            bus_a.score_clk = sc;
            bus_a.start     = st;
            bus_a.collision = co;
        end else begin
            bus_b.score_clk = sc;
            bus_b.start     = st;
            bus_b.collision = co;
        end
    endtask

    task automatic expect_snap(input int d, input string name, input int sc, input int lv,
                               input int hi, input bit run, input bit over);
        snap_t s;
        s.dut   = d;
        s.name  = name;
        s.score = sc;
        s.level = lv;
        s.high  = hi;
        s.run   = run;
        s.over  = over;
        snap_q.push_back(s);
    endtask

    task automatic tick(input int d, input int n);
        for (int i = 0; i < n; i++) begin
            drive(d, 1'b1, 1'b0, 1'b0);
            step();
            drive(d, 1'b0, 1'b0, 1'b0);
            step();
        end
    endtask

    task automatic pulse_start(input int d);
        drive(d, 1'b0, 1'b1, 1'b0);
        step();
        drive(d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic collide(input int d, input logic sc);
        drive(d, sc, 1'b0, 1'b1);
        step();
        drive(d, 1'b0, 1'b0, 1'b0);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        clr_n = 1'b0;
        drive(0, 1'b0, 1'b0, 1'b0);
        drive(1, 1'b0, 1'b0, 1'b0);
        repeat (2) step();
        expect_snap(0, "reset", 0, 0, 0, 1'b0, 1'b0);
        expect_snap(1, "reset", 0, 0, 0, 1'b0, 1'b0);
        step();
        clr_n = 1'b1;
        step();

        // five ticks at default thresholds: no level change
        pulse_start(0);
        tick(0, 5);
        expect_snap(0, "five_ticks", 5, 0, 0, 1'b1, 1'b0);

        // small thresholds: one-clk level latency
        pulse_start(1);
        lvl_qb.push_back(1);
        tick(1, 2);
        drive(1, 1'b1, 1'b0, 1'b0);
        step();
        expect_snap(1, "lat_before", 3, 0, 0, 1'b1, 1'b0);
        drive(1, 1'b0, 1'b0, 1'b0);
        step();
        expect_snap(1, "lat_after", 3, 1, 0, 1'b1, 1'b0);
        tick(1, 1);

        // tick and collision on the same clk at score 4
        collide(1, 1'b1);
        expect_snap(1, "tick_coll", 4, 1, 4, 1'b0, 1'b1);
        tick(1, 3);
        expect_snap(1, "over_hold", 4, 1, 4, 1'b0, 1'b1);

        // restart clears, then three level-ups and saturation at 8
        pulse_start(1);
        expect_snap(1, "restart_b", 0, 0, 4, 1'b1, 1'b0);
        lvl_qb.push_back(1);
        lvl_qb.push_back(2);
        lvl_qb.push_back(3);
        tick(1, 12);
        expect_snap(1, "saturate", 8, 3, 4, 1'b1, 1'b0);
        tick(1, 2);
        expect_snap(1, "sat_hold", 8, 3, 4, 1'b1, 1'b0);

        // high score survives a lower second game
        tick(0, 5);
        collide(0, 1'b0);
        expect_snap(0, "over10", 10, 0, 10, 1'b0, 1'b1);
        pulse_start(0);
        expect_snap(0, "restart_a", 0, 0, 10, 1'b1, 1'b0);
        tick(0, 6);
        pulse_start(0);
        expect_snap(0, "start_ign", 6, 0, 10, 1'b1, 1'b0);
        collide(0, 1'b0);
        expect_snap(0, "over6", 6, 0, 10, 1'b0, 1'b1);

        // default L1 threshold
        pulse_start(0);
        lvl_qa.push_back(1);
        tick(0, 100);
        expect_snap(0, "level1", 100, 1, 10, 1'b1, 1'b0);

        // asynchronous reset mid-RUN with score_clk held high across release
        drive(0, 1'b1, 1'b0, 1'b0);
        step();
        #2;
        clr_n = 1'b0;
        expect_snap(0, "async_rst", 0, 0, 0, 1'b0, 1'b0);
        expect_snap(1, "async_rst", 0, 0, 0, 1'b0, 1'b0);
        step();
        clr_n = 1'b1;
        step();
        drive(0, 1'b1, 1'b1, 1'b0);
        step();
        drive(0, 1'b1, 1'b0, 1'b0);
        step();
        expect_snap(0, "held_high", 0, 0, 0, 1'b1, 1'b0);
        drive(0, 1'b0, 1'b0, 1'b0);
        step();
        drive(0, 1'b1, 1'b0, 1'b0);
        step();
        expect_snap(0, "after_rel", 1, 0, 0, 1'b1, 1'b0);
        drive(0, 1'b0, 1'b0, 1'b0);
        repeat (2) step();

        total++;
        if (lvl_qa.size() != 0) begin
            bad++;
            $display("FAIL missing_level_up_a: got %0d pulses outstanding, want 0", lvl_qa.size());
        end
        total++;
        if (lvl_qb.size() != 0) begin
            bad++;
            $display("FAIL missing_level_up_b: got %0d pulses outstanding, want 0", lvl_qb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
